// File: rtl/rsa_timing_monitor.sv
// rsa_timing_monitor
//   Passive observer placed next to the RSA top. Each run opens on the
//   KeyGenStart pulse and closes on the decrypt finish pulse, or on counter
//   saturation if finish never arrives. One record per run (latency, whether
//   the decrypted message equals the captured plaintext, and a timeout flag)
//   goes into a small FIFO. A valid/ready reader drains the FIFO for timing
//   side-channel analysis.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   KeyGenStart       run start pulse (same net that drives the RSA top)
//   m                 original message, captured with KeyGenStart
//   m_decrypted       decrypt result, valid while finish=1
//   finish            decrypt-done pulse
//   busy              a run is in progress
//   rec_valid         FIFO head is valid
//   rec_ready         reader accepts the head this cycle
//   rec_cycles        head latency in clock cycles
//   rec_match         head: decrypted message matched the original
//   rec_timeout       head: counter saturated before finish
//   overflow          sticky, a record was dropped because the FIFO was full
//   mismatch_cnt      saturating count of mismatched (non-timeout) runs
module rsa_timing_monitor #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   KeyGenStart,
  input  logic [2*WIDTH-1:0]     m,
  input  logic [2*WIDTH-1:0]     m_decrypted,
  input  logic                   finish,
  output logic                   busy,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [CNT_WIDTH-1:0]   rec_cycles,
  output logic                   rec_match,
  output logic                   rec_timeout,
  output logic                   overflow,
  output logic [7:0]             mismatch_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = 2 * WIDTH;
  // Record layout: {timeout, match, cycles}
  localparam int RW = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [MW-1:0]          m_ref;
  logic                   push;
  logic [RW-1:0]          push_rec;

  logic [RW-1:0]          mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;
  logic                   full, pop, do_push;
  logic [RW-1:0]          head;

  // Run control: a finish seen in IDLE (even alongside KeyGenStart) never
  // produces a record, and KeyGenStart seen in RUN is ignored.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_rec  = '0;
    case (state)
      IDLE: begin
        if (KeyGenStart) state_nxt = RUN;
      end
      RUN: begin
        if (finish) begin
          push      = 1'b1;
          push_rec  = {1'b0, (m_decrypted == m_ref), cnt};
          state_nxt = IDLE;
        end else if (cnt == CNT_MAX) begin
          push      = 1'b1;
          push_rec  = {1'b1, 1'b0, CNT_MAX};
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // cnt is 1 right after the start edge, so a finish sampled on the next
  // edge reports a latency of 1. cnt stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      m_ref <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && KeyGenStart) begin
        m_ref <= m;
        cnt   <= CNT_WIDTH'(1);
      end else if (state == RUN && !finish && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy      = (state == RUN);
  assign full      = (count == FULL_LEVEL);
  assign rec_valid = (count != '0);
  assign pop       = rec_valid & rec_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO
  // goes through instead of being dropped.
  assign do_push   = push & (~full | pop);

  // FIFO bookkeeping, sticky overflow and the mismatch counter. The
  // mismatch counter counts a record even when the FIFO drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
      if (push && !push_rec[RW-1] && !push_rec[RW-2] && mismatch_cnt != 8'hFF)
        mismatch_cnt <= mismatch_cnt + 8'd1;
    end
  end

  // Storage needs no reset: the head is only exposed while rec_valid=1.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_rec;
  end

  assign head        = mem[rd_ptr];
  assign rec_cycles  = rec_valid ? head[CNT_WIDTH-1:0] : '0;
  assign rec_match   = rec_valid & head[RW-2];
  assign rec_timeout = rec_valid & head[RW-1];

endmodule

// File: tb/tb_rsa_timing_monitor.sv
// tb_rsa_timing_monitor
//   Drives two monitors from the same inputs: one with the default 16-bit
//   counter and one with a 4-bit counter, so that timeouts happen quickly.
//   A model based on timestamps and queues predicts every output of both
//   instances on each falling edge. Directed scenarios add literal
//   expectations. A long randomized phase follows them.
module tb_rsa_timing_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        KeyGenStart = 1'b0;
  logic [15:0] m = '0;
  logic [15:0] m_decrypted = '0;
  logic        finish = 1'b0;
  logic        rec_ready = 1'b0;

  logic        busy0, rec_valid0, rec_match0, rec_timeout0, overflow0;
  logic [15:0] rec_cycles0;
  logic [7:0]  mismatch_cnt0;
  logic        busy1, rec_valid1, rec_match1, rec_timeout1, overflow1;
  logic [3:0]  rec_cycles1;
  logic [7:0]  mismatch_cnt1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int busy_cnt = 0;

  always #5 clk = ~clk;

  rsa_timing_monitor #(.WIDTH(8), .CNT_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .KeyGenStart(KeyGenStart), .m(m),
    .m_decrypted(m_decrypted), .finish(finish), .busy(busy0),
    .rec_valid(rec_valid0), .rec_ready(rec_ready), .rec_cycles(rec_cycles0),
    .rec_match(rec_match0), .rec_timeout(rec_timeout0), .overflow(overflow0),
    .mismatch_cnt(mismatch_cnt0)
  );

  rsa_timing_monitor #(.WIDTH(8), .CNT_WIDTH(4), .DEPTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .KeyGenStart(KeyGenStart), .m(m),
    .m_decrypted(m_decrypted), .finish(finish), .busy(busy1),
    .rec_valid(rec_valid1), .rec_ready(rec_ready), .rec_cycles(rec_cycles1),
    .rec_match(rec_match1), .rec_timeout(rec_timeout1), .overflow(overflow1),
    .mismatch_cnt(mismatch_cnt1)
  );

  // Reference model: record layout {timeout, match, cycles[15:0]}
  typedef logic [17:0] rec_t;
  rec_t        mq [2][$];
  bit          m_run [2] = '{0, 0};
  int          m_start [2] = '{0, 0};
  logic [15:0] m_ref [2] = '{16'h0, 16'h0};
  bit          m_ovf [2] = '{0, 0};
  int          m_mm [2] = '{0, 0};
  int          edge_no = 0;

  function automatic int max_lat(input int i);
    return (i == 0) ? 65535 : 15;
  endfunction

  task automatic model_edge(input int i);
    bit   have_rec;
    bit   do_pop;
    rec_t r;
    int   lat;
    have_rec = 1'b0;
    r = '0;
    do_pop = (mq[i].size() > 0) && rec_ready;
    if (!m_run[i]) begin
      if (KeyGenStart) begin
        m_run[i]   = 1'b1;
        m_start[i] = edge_no;
        m_ref[i]   = m;
      end
    end else begin
      lat = edge_no - m_start[i];
      if (finish) begin
        have_rec = 1'b1;
        r = {1'b0, (m_decrypted == m_ref[i]), 16'(lat)};
        m_run[i] = 1'b0;
      end else if (lat == max_lat(i)) begin
        have_rec = 1'b1;
        r = {1'b1, 1'b0, 16'(max_lat(i))};
        m_run[i] = 1'b0;
      end
    end
    if (do_pop) void'(mq[i].pop_front());
    if (have_rec) begin
      if (!r[17] && !r[16] && m_mm[i] < 255) m_mm[i]++;
      if (mq[i].size() < 4) mq[i].push_back(r);
      else m_ovf[i] = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        m_run[i] = 1'b0;
        m_ovf[i] = 1'b0;
        m_mm[i]  = 0;
      end
    end else begin
      edge_no++;
      for (int i = 0; i < 2; i++) model_edge(i);
    end
  end

  task automatic check_output(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_lane(input int i, input logic b, input logic v,
                              input longint cyc, input logic mt, input logic to,
                              input logic ov, input logic [7:0] mc);
    rec_t h;
    check_output($sformatf("L%0d busy", i), longint'(b), longint'(m_run[i]));
    check_output($sformatf("L%0d rec_valid", i), longint'(v), longint'(mq[i].size() > 0));
    if (mq[i].size() > 0) begin
      h = mq[i][0];
      check_output($sformatf("L%0d rec_cycles", i), cyc, longint'(h[15:0]));
      check_output($sformatf("L%0d rec_match", i), longint'(mt), longint'(h[16]));
      check_output($sformatf("L%0d rec_timeout", i), longint'(to), longint'(h[17]));
    end
    check_output($sformatf("L%0d overflow", i), longint'(ov), longint'(m_ovf[i]));
    check_output($sformatf("L%0d mismatch_cnt", i), longint'(mc), longint'(m_mm[i]));
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      compare_lane(0, busy0, rec_valid0, longint'(rec_cycles0), rec_match0,
                   rec_timeout0, overflow0, mismatch_cnt0);
      compare_lane(1, busy1, rec_valid1, longint'(rec_cycles1), rec_match1,
                   rec_timeout1, overflow1, mismatch_cnt1);
      if (busy0) busy_cnt++;
    end
  end

  // One complete run. Entered and left 2 time units after a rising edge.
  task automatic apply_stimulus(input logic [15:0] mv, input logic [15:0] dv,
                                input int lat, input bit ready_at_finish);
    KeyGenStart = 1'b1;
    m = mv;
    @(posedge clk);
    #2 KeyGenStart = 1'b0;
    repeat (lat - 1) @(posedge clk);
    #2;
    finish = 1'b1;
    m_decrypted = dv;
    if (ready_at_finish) rec_ready = 1'b1;
    @(posedge clk);
    #2 finish = 1'b0;
    if (ready_at_finish) rec_ready = 1'b0;
  endtask

  task automatic drain_one();
    rec_ready = 1'b1;
    @(posedge clk);
    #2 rec_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] mv;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #3;
    check_output("reset busy", longint'(busy0), 0);
    check_output("reset rec_valid", longint'(rec_valid0), 0);
    check_output("reset rec_cycles", longint'(rec_cycles0), 0);
    check_output("reset overflow", longint'(overflow0), 0);
    check_output("reset mismatch_cnt", longint'(mismatch_cnt0), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] basic latency and match");
    busy_cnt = 0;
    apply_stimulus(16'h0041, 16'h0041, 37, 1'b0);
    check_output("t1 busy cycles", busy_cnt, 37);
    check_output("t1 rec_valid", longint'(rec_valid0), 1);
    check_output("t1 rec_cycles", longint'(rec_cycles0), 37);
    check_output("t1 rec_match", longint'(rec_match0), 1);
    check_output("t1 rec_timeout", longint'(rec_timeout0), 0);
    check_output("t1 mismatch_cnt", longint'(mismatch_cnt0), 0);
    drain_one();

    $display("[TB] mismatch counting and saturation");
    apply_stimulus(16'h0041, 16'h0042, 37, 1'b0);
    check_output("t2 rec_match", longint'(rec_match0), 0);
    check_output("t2 mismatch_cnt", longint'(mismatch_cnt0), 1);
    rec_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      mv = 16'($urandom);
      apply_stimulus(mv, mv ^ 16'h0001, $urandom_range(1, 3), 1'b0);
    end
    check_output("t2 mismatch sat", longint'(mismatch_cnt0), 255);
    check_output("t2 small mismatch sat", longint'(mismatch_cnt1), 255);
    rec_ready = 1'b0;

    $display("[TB] overflow on full FIFO");
    do_reset();
    for (int k = 0; k < 5; k++) begin
      mv = 16'($urandom);
      apply_stimulus(mv, mv, 10 + k, 1'b0);
    end
    check_output("t3 overflow", longint'(overflow0), 1);
    for (int k = 0; k < 4; k++) begin
      check_output("t3 drain cycles", longint'(rec_cycles0), 10 + k);
      check_output("t3 small drain cycles", longint'(rec_cycles1), 10 + k);
      drain_one();
    end
    check_output("t3 empty", longint'(rec_valid0), 0);

    $display("[TB] push and pop on a full FIFO");
    do_reset();
    for (int k = 0; k < 4; k++) begin
      mv = 16'($urandom);
      apply_stimulus(mv, mv, 10 + k, 1'b0);
    end
    apply_stimulus(16'h1234, 16'h1234, 20, 1'b1);
    check_output("t4 overflow", longint'(overflow0), 0);
    check_output("t4 head", longint'(rec_cycles0), 11);
    drain_one();
    check_output("t4 head", longint'(rec_cycles0), 12);
    drain_one();
    check_output("t4 head", longint'(rec_cycles0), 13);
    drain_one();
    check_output("t4 head", longint'(rec_cycles0), 20);
    drain_one();
    check_output("t4 empty", longint'(rec_valid0), 0);

    $display("[TB] timeout with a 4-bit counter");
    do_reset();
    KeyGenStart = 1'b1;
    m = 16'h00AA;
    @(posedge clk);
    #2 KeyGenStart = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    check_output("t5 small busy", longint'(busy1), 0);
    check_output("t5 small rec_valid", longint'(rec_valid1), 1);
    check_output("t5 small rec_cycles", longint'(rec_cycles1), 15);
    check_output("t5 small rec_timeout", longint'(rec_timeout1), 1);
    check_output("t5 small rec_match", longint'(rec_match1), 0);
    check_output("t5 busy", longint'(busy0), 1);
    repeat (2) @(posedge clk);
    #2;
    finish = 1'b1;
    m_decrypted = 16'h00AA;
    @(posedge clk);
    #2 finish = 1'b0;
    check_output("t5 rec_cycles", longint'(rec_cycles0), 18);
    check_output("t5 rec_match", longint'(rec_match0), 1);
    drain_one();
    check_output("t5 small late finish", longint'(rec_valid1), 0);
    check_output("t5 empty", longint'(rec_valid0), 0);

    $display("[TB] start with finish in IDLE, reset mid-run");
    KeyGenStart = 1'b1;
    finish = 1'b1;
    m = 16'h5555;
    m_decrypted = 16'h5555;
    @(posedge clk);
    #2;
    KeyGenStart = 1'b0;
    finish = 1'b0;
    check_output("t6 busy", longint'(busy0), 1);
    check_output("t6 no record", longint'(rec_valid0), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("t6 reset busy", longint'(busy0), 0);
    check_output("t6 reset small busy", longint'(busy1), 0);
    check_output("t6 reset rec_valid", longint'(rec_valid0), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    apply_stimulus(16'h0777, 16'h0777, 5, 1'b0);
    check_output("t6 rec_cycles", longint'(rec_cycles0), 5);
    check_output("t6 rec_match", longint'(rec_match0), 1);
    drain_one();

    $display("[TB] randomized traffic");
    for (int k = 0; k < 3000; k++) begin
      KeyGenStart = ($urandom_range(0, 7) == 0);
      finish = ($urandom_range(0, 5) == 0);
      m = 16'($urandom);
      m_decrypted = ($urandom_range(0, 1) == 1) ? m_ref[0] : 16'($urandom);
      rec_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #2;
    end
    KeyGenStart = 1'b0;
    finish = 1'b0;
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_timing_monitor.md
Name: rsa_timing_monitor

Overview:
- Downstream observer for the RSA top: watches the keygen start pulse, the plaintext message and the decrypt finish/m_decrypted outputs.
- Measures end-to-end latency in clock cycles for each run and checks that the decrypted message equals the original.
- Queues one record per run in a small FIFO, drained by a valid/ready reader, for timing side-channel analysis.

Parameters:
- WIDTH, 8, prime width; message width is 2*WIDTH, matching the RSA top.
- CNT_WIDTH, 16, latency counter width.
- DEPTH, 4, record FIFO depth (power of two, >=2).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- KeyGenStart  input  1  run start pulse (same net that drives the RSA top)
- m  input  2*WIDTH  original message, sampled with KeyGenStart
- m_decrypted  input  2*WIDTH  decrypt result, valid when finish=1
- finish  input  1  decrypt-done pulse
- busy  output  1  run in progress
- rec_valid  output  1  FIFO head valid
- rec_ready  input  1  reader accepts head
- rec_cycles  output  CNT_WIDTH  head latency
- rec_match  output  1  head: m_decrypted == captured m
- rec_timeout  output  1  head: counter saturated before finish
- overflow  output  1  sticky, record dropped because FIFO was full
- mismatch_cnt  output  8  saturating count of mismatched runs

Behaviour:
- Reset (async, rst_n=0): FSM returns to IDLE; FIFO empties. All outputs 0: busy, rec_valid, rec_cycles, rec_match, rec_timeout, overflow, mismatch_cnt. Reset mid-run discards the run with no record.
- FSM states: IDLE, RUN.
- IDLE, KeyGenStart=1 at an edge:
  - capture m into m_ref; cnt<=1; go to RUN.
  - busy=1 from the next cycle.
  - finish in IDLE is ignored, including when it is in the same cycle as KeyGenStart; the start wins.
- RUN, each edge with finish=0 and cnt < 2^CNT_WIDTH-1: cnt<=cnt+1. KeyGenStart in RUN is ignored.
- RUN, finish=1 at an edge:
  - push record {timeout=0, match=(m_decrypted==m_ref), cycles=cnt}; go to IDLE.
  - Latency definition: finish sampled on the edge after the start edge gives cycles=1.
  - A KeyGenStart on the very next edge starts a new run.
- RUN, finish=0 and cnt == 2^CNT_WIDTH-1:
  - push record {timeout=1, match=0, cycles=all ones}; go to IDLE.
  - A later finish arriving in IDLE is ignored.
- mismatch_cnt: increments on each pushed record with match=0 and timeout=0; saturates at 255. It counts even when the push is dropped.
- FIFO behaviour:
  - rec_* shows the head combinationally from storage; rec_valid = not empty.
  - Pop on rec_valid & rec_ready at the edge.
  - Push while full: the record is dropped and overflow<=1 (sticky until reset), unless a pop happens on the same edge. In that case both take effect, count is unchanged, and nothing is dropped.
  - Push and pop on an empty FIFO: the push is stored and the pop is a no-op, because rec_valid=0.
  - Pointers wrap modulo DEPTH; occupancy counter is 0..DEPTH.
  - Record write latency: rec_valid rises the cycle after the finish edge.
- Width rules: the comparison is the full 2*WIDTH bits; cnt never wraps.

Test Plan:
1. Reset, then KeyGenStart with m=16'h0041; finish 37 cycles after the start edge with m_decrypted=16'h0041 -> one record: cycles=37, match=1, timeout=0; busy high for 37 cycles; mismatch_cnt=0.
2. Same as 1 but m_decrypted=16'h0042 -> record match=0, mismatch_cnt=1. Repeat 300 runs -> mismatch_cnt holds at 255.
3. rec_ready=0; run 5 back-to-back runs with latencies 10,11,12,13,14 -> 4 records queued, overflow=1. Drain -> cycles 10,11,12,13 in order; rec_valid then drops.
4. FIFO full and rec_ready=1 on the edge where finish pushes -> no drop, overflow stays 0, order preserved.
5. CNT_WIDTH=4, no finish -> after 15 counted cycles record cycles=15, timeout=1, FSM in IDLE. A late finish adds no record.
6. KeyGenStart and finish together in IDLE -> run starts, no record. Assert rst_n=0 mid-run -> busy=0, FIFO empty; the next run measures correctly from cnt=1.
